// File: rtl/arima_anomaly_detection.sv
// arima_anomaly_detection
//   Streaming ARIMA(p,d,q) one-step-ahead predictor with anomaly flagging in
//   signed Q15 fixed point. It reads the model configuration and the sample
//   series from a word-addressed synchronous RAM that has one cycle of read
//   latency. Each prediction is written back to WR_BASE+t. The label output
//   flags samples that deviate from their prediction by more than T.
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   start        : level; sampled in IDLE to begin a run
//   data_in      : RAM read data, valid the cycle after rden
//   address_r    : RAM read address
//   rden         : RAM read strobe
//   address_w    : RAM write address
//   wren         : RAM write strobe
//   prediction_o : RAM write data; holds the last prediction
//   label        : 1 = last observed sample is anomalous
//   overflow     : sticky saturation / config-clip flag
module arima_anomaly_detection #(
  parameter int Q       = 15,
  parameter int N       = 32,
  parameter int D_MAX   = 10,
  parameter int P_MAX   = 10,
  parameter int Q_MAX   = 10,
  parameter int WR_BASE = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_in,
  output logic [31:0]  address_r,
  output logic         rden,
  output logic [31:0]  address_w,
  output logic         wren,
  output logic [N-1:0] prediction_o,
  output logic         label,
  output logic         overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_RDX, S_DIFF, S_MAC, S_INTEG, S_WR, S_DONE
  } state_t;

  typedef struct packed {
    logic         ovf;
    logic [N-1:0] v;
  } sat_t;

  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
  localparam logic [31:0]  WR_BASE_W = 32'(WR_BASE);

  // One extra sign bit: the sum overflowed if the top two bits disagree.
  function automatic sat_t f_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    sat_t r;
    s     = {a[N-1], a} + {b[N-1], b};
    r.ovf = s[N] ^ s[N-1];
    r.v   = r.ovf ? (s[N] ? MINV : MAXV) : s[N-1:0];
    return r;
  endfunction

  function automatic sat_t f_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    sat_t r;
    s     = {a[N-1], a} - {b[N-1], b};
    r.ovf = s[N] ^ s[N-1];
    r.v   = r.ovf ? (s[N] ? MINV : MAXV) : s[N-1:0];
    return r;
  endfunction

  // Full 2N-bit product, rescaled by >>>Q, then clamped back to N bits.
  function automatic sat_t f_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    logic [2*N-1:0] sh;
    logic [N:0]     hi;
    sat_t r;
    p     = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
    sh    = $signed(p) >>> Q;
    hi    = sh[2*N-1:N-1];
    r.ovf = !((&hi) || !(|hi));
    r.v   = r.ovf ? (sh[2*N-1] ? MINV : MAXV) : sh[N-1:0];
    return r;
  endfunction

  state_t       r_state, w_next;
  logic [3:0]   r_d, r_p, r_q;
  logic [N-1:0] r_thr;
  logic [31:0]  r_s, r_t;
  logic [N-1:0] r_phi   [P_MAX];
  logic [N-1:0] r_theta [Q_MAX];
  logic [N-1:0] r_yh    [P_MAX];
  logic [N-1:0] r_eh    [Q_MAX];
  logic [N-1:0] r_prev  [D_MAX];
  logic [N-1:0] r_yhat, r_acc, r_pred;
  logic [4:0]   r_idx, r_cfg_cnt, r_cfg_paddr;
  logic         r_cfg_pend, r_label, r_ovf;

  // Combinational datapath
  logic [4:0]   w_pq, w_cfg_words, w_coef_k;
  logic [31:0]  w_db;
  logic         w_cfg_issue, w_cfg_done;
  logic [N-1:0] w_v [D_MAX+1];
  logic [N-1:0] w_s [D_MAX+1];
  logic         w_diff_ovf, w_int_ovf, w_mac_do, w_is_ar, w_label, w_dp_ovf;
  logic [3:0]   w_sel;
  sat_t         w_e, w_prod, w_macc;
  logic [N:0]   w_err, w_abs;

  assign w_pq        = {1'b0, r_p} + {1'b0, r_q};
  assign w_cfg_words = 5'd5 + w_pq;
  assign w_db        = {27'd0, w_cfg_words};
  // p and q are captured by the time the issue counter passes word 4.
  assign w_cfg_issue = (r_cfg_cnt < 5'd5) || (r_cfg_cnt < w_cfg_words);
  assign w_cfg_done  = !w_cfg_issue && !r_cfg_pend;
  assign w_coef_k    = r_cfg_paddr - 5'd5;

  // NOTE: every always_comb variable is defaulted before any branch so no latch is inferred.
  always_comb begin
    sat_t tmp;
    tmp        = '0;
    w_diff_ovf = 1'b0;
    w_int_ovf  = 1'b0;
    w_v[0]     = data_in;
    for (int k = 0; k < D_MAX; k++) begin
      if (4'(k) < r_d) begin
        tmp        = f_sub(w_v[k], r_prev[k]);
        w_v[k+1]   = tmp.v;
        w_diff_ovf = w_diff_ovf | tmp.ovf;
      end else begin
        w_v[k+1] = w_v[k];
      end
    end
    // Re-integration uses the stage values as updated by this sample.
    w_s[0] = r_acc;
    for (int k = 0; k < D_MAX; k++) begin
      if (4'(k) < r_d) begin
        tmp       = f_add(w_s[k], r_prev[k]);
        w_s[k+1]  = tmp.v;
        w_int_ovf = w_int_ovf | tmp.ovf;
      end else begin
        w_s[k+1] = w_s[k];
      end
    end
  end

  assign w_e      = f_sub(w_v[D_MAX], r_yhat);
  assign w_mac_do = r_idx < w_pq;
  assign w_is_ar  = r_idx < {1'b0, r_p};
  assign w_sel    = w_is_ar ? r_idx[3:0] : 4'(r_idx - {1'b0, r_p});
  assign w_prod   = w_is_ar ? f_mul(r_phi[w_sel], r_yh[w_sel])
                            : f_mul(r_theta[w_sel], r_eh[w_sel]);
  assign w_macc   = f_add(r_acc, w_prod.v);

  // The anomaly distance is computed exactly in N+1 bits; it only feeds a compare.
  assign w_err   = {data_in[N-1], data_in} - {r_pred[N-1], r_pred};
  assign w_abs   = w_err[N] ? -w_err : w_err;
  assign w_label = (r_t != 32'd0) && (w_abs > {1'b0, r_thr});

  assign w_dp_ovf = ((r_state == S_DIFF) && (w_diff_ovf || w_e.ovf))
                 || ((r_state == S_MAC) && w_mac_do && (w_prod.ovf || w_macc.ovf))
                 || ((r_state == S_INTEG) && w_int_ovf);

  always_comb begin
    w_next    = r_state;
    rden      = 1'b0;
    address_r = '0;
    wren      = 1'b0;
    address_w = '0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CFG;
      S_CFG: begin
        rden      = w_cfg_issue;
        address_r = w_cfg_issue ? {27'd0, r_cfg_cnt} : '0;
        if (w_cfg_done) w_next = (r_s == 32'd0) ? S_DONE : S_RDX;
      end
      S_RDX: begin
        rden      = 1'b1;
        address_r = w_db + r_t;
        w_next    = S_DIFF;
      end
      S_DIFF:  w_next = S_MAC;
      S_MAC:   if (r_idx + 5'd1 >= w_pq) w_next = S_INTEG;
      S_INTEG: w_next = S_WR;
      S_WR: begin
        wren      = 1'b1;
        address_w = WR_BASE_W + r_t;
        w_next    = (r_t == r_s - 32'd1) ? S_DONE : S_RDX;
      end
      S_DONE:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_d <= '0; r_p <= '0; r_q <= '0;
      r_thr <= '0; r_s <= '0; r_t <= '0;
      r_yhat <= '0; r_acc <= '0; r_pred <= '0;
      r_idx <= '0; r_cfg_cnt <= '0; r_cfg_paddr <= '0;
      r_cfg_pend <= 1'b0; r_label <= 1'b0; r_ovf <= 1'b0;
      // NOTE: histories are register arrays cleared on reset, since the MAC reads them before they fill.
      for (int k = 0; k < P_MAX; k++) begin r_phi[k] <= '0; r_yh[k] <= '0; end
      for (int k = 0; k < Q_MAX; k++) begin r_theta[k] <= '0; r_eh[k] <= '0; end
      for (int k = 0; k < D_MAX; k++) r_prev[k] <= '0;
    end else begin
      r_state <= w_next;
      r_ovf   <= r_ovf | w_dp_ovf;
      case (r_state)
        S_IDLE: begin
          r_cfg_cnt <= '0; r_cfg_pend <= 1'b0;
          r_t <= '0; r_yhat <= '0; r_idx <= '0; r_label <= 1'b0;
          for (int k = 0; k < P_MAX; k++) r_yh[k] <= '0;
          for (int k = 0; k < Q_MAX; k++) r_eh[k] <= '0;
          for (int k = 0; k < D_MAX; k++) r_prev[k] <= '0;
        end
        S_CFG: begin
          if (w_cfg_issue) r_cfg_cnt <= r_cfg_cnt + 5'd1;
          r_cfg_pend  <= w_cfg_issue;
          r_cfg_paddr <= r_cfg_cnt;
          if (r_cfg_pend) begin
            case (r_cfg_paddr)
              5'd0: if (data_in > N'(D_MAX)) begin r_d <= 4'(D_MAX); r_ovf <= 1'b1; end
                    else r_d <= data_in[3:0];
              5'd1: if (data_in > N'(P_MAX)) begin r_p <= 4'(P_MAX); r_ovf <= 1'b1; end
                    else r_p <= data_in[3:0];
              5'd2: if (data_in > N'(Q_MAX)) begin r_q <= 4'(Q_MAX); r_ovf <= 1'b1; end
                    else r_q <= data_in[3:0];
              5'd3: r_thr <= data_in;
              5'd4: r_s   <= 32'(data_in);
              default: begin
                if (w_coef_k < {1'b0, r_p}) r_phi[w_coef_k[3:0]] <= data_in;
                else r_theta[4'(w_coef_k - {1'b0, r_p})] <= data_in;
              end
            endcase
          end
        end
        S_DIFF: begin
          for (int k = 0; k < D_MAX; k++) if (4'(k) < r_d) r_prev[k] <= w_v[k];
          for (int k = P_MAX-1; k > 0; k--) r_yh[k] <= r_yh[k-1];
          r_yh[0] <= w_v[D_MAX];
          for (int k = Q_MAX-1; k > 0; k--) r_eh[k] <= r_eh[k-1];
          r_eh[0] <= w_e.v;
          r_label <= w_label;
          r_acc   <= '0;
          r_idx   <= '0;
        end
        S_MAC: begin
          if (w_mac_do) r_acc <= w_macc.v;
          r_idx <= r_idx + 5'd1;
        end
        S_INTEG: begin
          r_yhat <= r_acc;
          r_pred <= w_s[D_MAX];
        end
        S_WR:    r_t <= r_t + 32'd1;
        default: ;
      endcase
    end
  end

  assign prediction_o = r_pred;
  assign label        = r_label;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_arima_anomaly_detection.sv
// Directed testbench for arima_anomaly_detection with a behavioural
// one-cycle-latency RAM and a log of every write-back.
module tb_arima_anomaly_detection;

  localparam int WR_BASE = 1024;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] data_in, address_r, address_w, prediction_o;
  logic        rden, wren, label, overflow;

  logic [31:0] ram     [0:255];
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic        wr_lab  [0:63];
  int          n_wr = 0, n_both = 0;
  int          n_checks = 0, n_fail = 0;

  arima_anomaly_detection #(.WR_BASE(WR_BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .address_r(address_r), .rden(rden), .address_w(address_w), .wren(wren),
    .prediction_o(prediction_o), .label(label), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rden) data_in <= ram[address_r[7:0]];
    if (wren) begin
      wr_addr[n_wr[5:0]] <= address_w;
      wr_data[n_wr[5:0]] <= prediction_o;
      wr_lab[n_wr[5:0]]  <= label;
      n_wr <= n_wr + 1;
    end
    if (rden && wren) n_both <= n_both + 1;
  end

  task automatic do_reset();
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [31:0] d, p, q, t, s);
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[0] = d; ram[1] = p; ram[2] = q; ram[3] = t; ram[4] = s;
  endtask

  task automatic run_dut(input int s, input string name, output int base);
    base  = n_wr;
    start = 1'b1;
    for (int c = 0; c < 3000 && (n_wr - base) < s; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_wr - base != s) begin
      n_fail++;
      $display("FAIL %s_writes: got %0d writes, expected %0d", name, n_wr - base, s);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({rden, wren, label, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {rden, wren, label, overflow});
    end
    n_checks++;
    if ({address_r, address_w, prediction_o} !== 96'd0) begin
      n_fail++; $display("FAIL reset_buses: got %h %h %h, expected 0", address_r, address_w, prediction_o);
    end
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rden !== 1'b1 || address_r !== 32'd0) begin
      n_fail++; $display("FAIL reset_first_read: got rden=%b addr=%0d, expected 1/0", rden, address_r);
    end
    @(negedge clk);
    n_checks++;
    if (rden !== 1'b1 || address_r !== 32'd1) begin
      n_fail++; $display("FAIL reset_second_read: got rden=%b addr=%0d, expected 1/1", rden, address_r);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    do_reset();
  endtask

  task automatic setup_ar1();
    set_cfg(0, 1, 0, 32'h4000_0000, 3);
    ram[5] = 32'd16384;
    ram[6] = 32'd32768; ram[7] = 32'd65536; ram[8] = 32'd0;
  endtask

  task automatic check_ar1(input string name);
    logic [31:0] ep [3];
    int base;
    ep = '{32'd16384, 32'd32768, 32'd0};
    run_dut(3, name, base);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_data[base+i] !== ep[i] || wr_addr[base+i] !== 32'(WR_BASE + i) || wr_lab[base+i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_pred[%0d]: got %0d @%0d lab=%b, expected %0d @%0d lab=0",
                 name, i, wr_data[base+i], wr_addr[base+i], wr_lab[base+i], ep[i], WR_BASE + i);
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL %s_overflow: got %b, expected 0", name, overflow); end
  endtask

  task automatic test_ar1();
    do_reset();
    setup_ar1();
    check_ar1("ar1");
  endtask

  task automatic test_random_walk();
    logic [31:0] ep [3];
    int base;
    ep = '{32'd100, 32'd200, 32'd350};
    do_reset();
    set_cfg(1, 0, 0, 32'h4000_0000, 3);
    ram[5] = 32'd100; ram[6] = 32'd200; ram[7] = 32'd350;
    run_dut(3, "rwalk", base);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_data[base+i] !== ep[i]) begin
        n_fail++; $display("FAIL rwalk_pred[%0d]: got %0d, expected %0d", i, wr_data[base+i], ep[i]);
      end
    end
  endtask

  task automatic test_label();
    logic [31:0] x [5];
    logic        el [5];
    int base;
    x  = '{32'd8192, 32'd8192, 32'd24576, 32'd8192, 32'd11469};
    el = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_cfg(1, 0, 0, 32'd3277, 5);
    for (int i = 0; i < 5; i++) ram[5+i] = x[i];
    run_dut(5, "label", base);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (wr_lab[base+i] !== el[i] || wr_data[base+i] !== x[i]) begin
        n_fail++;
        $display("FAIL label[%0d]: got lab=%b pred=%0d, expected lab=%b pred=%0d",
                 i, wr_lab[base+i], wr_data[base+i], el[i], x[i]);
      end
    end
  endtask

  task automatic test_ma();
    logic [31:0] ep [2];
    int base;
    ep = '{32'd16384, 32'd8192};
    do_reset();
    set_cfg(0, 0, 1, 32'h4000_0000, 2);
    ram[5] = 32'd16384; ram[6] = 32'd32768; ram[7] = 32'd32768;
    run_dut(2, "ma1", base);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (wr_data[base+i] !== ep[i]) begin
        n_fail++; $display("FAIL ma1_pred[%0d]: got %0d, expected %0d", i, wr_data[base+i], ep[i]);
      end
    end
  endtask

  task automatic test_diff2();
    logic [31:0] ep [3];
    int base;
    ep = '{32'd0, 32'd20, 32'd50};
    do_reset();
    set_cfg(2, 0, 0, 32'h4000_0000, 3);
    ram[5] = 32'd0; ram[6] = 32'd10; ram[7] = 32'd30;
    run_dut(3, "diff2", base);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_data[base+i] !== ep[i]) begin
        n_fail++; $display("FAIL diff2_pred[%0d]: got %0d, expected %0d", i, wr_data[base+i], ep[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] ep [3];
    logic        el [3];
    int base;
    ep = '{32'h7FFF_FFFF, 32'd0, 32'd0};
    el = '{1'b0, 1'b1, 1'b0};
    do_reset();
    set_cfg(0, 1, 0, 32'h4000_0000, 3);
    ram[5] = 32'd65536; ram[6] = 32'h7FFF_0000; ram[7] = 32'd0; ram[8] = 32'd0;
    run_dut(3, "sat", base);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_data[base+i] !== ep[i] || wr_lab[base+i] !== el[i]) begin
        n_fail++;
        $display("FAIL sat_pred[%0d]: got %h lab=%b, expected %h lab=%b",
                 i, wr_data[base+i], wr_lab[base+i], ep[i], el[i]);
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b, expected 1", overflow); end
  endtask

  task automatic test_s_zero();
    int base;
    do_reset();
    set_cfg(0, 1, 0, 32'h4000_0000, 0);
    ram[5] = 32'd16384; ram[6] = 32'd32768;
    run_dut(0, "szero", base);
  endtask

  task automatic test_clip_abort();
    int base;
    bit seen;
    do_reset();
    set_cfg(0, 12, 0, 32'h4000_0000, 1);
    ram[5] = 32'd16384; ram[15] = 32'd32768; ram[16] = 32'd12345; ram[17] = 32'd12345;
    run_dut(1, "clip", base);
    n_checks++;
    if (wr_data[base] !== 32'd16384 || wr_addr[base] !== 32'(WR_BASE) || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clip: got pred=%0d @%0d ovf=%b, expected 16384 @%0d ovf=1",
               wr_data[base], wr_addr[base], overflow, WR_BASE);
    end
    // Abort a run during its first MAC cycle, then repeat it from scratch.
    setup_ar1();
    start = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (rden === 1'b1 && address_r === 32'd6) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL abort_reach_rdx: got no sample read, expected read of 6"); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({rden, wren, label, overflow, address_r, address_w, prediction_o} !== 100'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got rden=%b wren=%b lab=%b ovf=%b ar=%h aw=%h pred=%h, expected all 0",
               rden, wren, label, overflow, address_r, address_w, prediction_o);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_ar1("rerun");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ar1();
    test_random_walk();
    test_label();
    test_ma();
    test_diff2();
    test_saturation();
    test_s_zero();
    test_clip_abort();
    n_checks++;
    if (n_both != 0) begin
      n_fail++; $display("FAIL rd_wr_exclusive: got %0d overlapping cycles, expected 0", n_both);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
